// File: rtl/gf180mcu_fd_sc_mcu9t5v0__latfifo_pkg.sv
// Shared constants for the latch-FIFO cell: default geometry, pointer sizing
// and the bit positions of the sticky error flags.
package gf180mcu_fd_sc_mcu9t5v0__latfifo_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_DEPTH = 4;

  localparam int FLAG_OVF  = 0;
  localparam int FLAG_UDF  = 1;
  localparam int NUM_FLAGS = 2;

  typedef logic [NUM_FLAGS-1:0] flags_t;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__latfifo_mem.sv
// FIFO storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
module gf180mcu_fd_sc_mcu9t5v0__latfifo_mem #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__latfifo.sv
// Single-clock FIFO: pointers, occupancy, sticky OVF/UDF flags and the Q
// output stage (show-ahead or registered). Storage lives in the _mem sub-module.
module gf180mcu_fd_sc_mcu9t5v0__latfifo
  import gf180mcu_fd_sc_mcu9t5v0__latfifo_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int SHOWAHEAD = 1
) (
`ifdef USE_POWER_PINS
  inout  wire                           VDD,
  inout  wire                           VSS,
`endif
  input  logic                          CLK,
  input  logic                          R,
  input  logic [WIDTH-1:0]              D,
  input  logic                          E,
  input  logic                          RE,
  input  logic                          CLR,
  output logic [WIDTH-1:0]              Q,
  output logic                          FULL,
  output logic                          EMPTY,
  output logic [ptr_w(DEPTH):0]         CNT,
  output logic                          OVF,
  output logic                          UDF
);

  localparam int AW = ptr_w(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  flags_t           flg_q, flg_d;
  logic [WIDTH-1:0] qh_q, qh_d, head;
  logic             full, empty, push, pop;

  gf180mcu_fd_sc_mcu9t5v0__latfifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk_i   (CLK),
    .we_i    (push),
    .waddr_i (wr_q),
    .wdata_i (D),
    .raddr_i (rd_q),
    .rdata_o (head)
  );

  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);
  // A pop frees a slot in the same edge, so a full FIFO still accepts a push alongside it.
  assign pop   = RE & ~empty & ~CLR;
  assign push  = E & (~full | (RE & ~empty)) & ~CLR;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    flg_d = flg_q;
    qh_d  = qh_q;
    if (CLR) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
      // Freeze whatever Q was showing so a flush never exposes stale storage.
      if (SHOWAHEAD != 0) qh_d = Q;
    end else begin
      if (push) wr_d = wr_q + AW'(1);
      if (pop) begin
        rd_d = rd_q + AW'(1);
        qh_d = head;
      end
      if (push && !pop)      cnt_d = cnt_q + CW'(1);
      else if (pop && !push) cnt_d = cnt_q - CW'(1);
      if (E && full && !RE) flg_d[FLAG_OVF] = 1'b1;
      if (RE && empty)      flg_d[FLAG_UDF] = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (R) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      flg_q <= '0;
      qh_q  <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      flg_q <= flg_d;
      qh_q  <= qh_d;
    end
  end

  assign Q     = ((SHOWAHEAD != 0) && !empty) ? head : qh_q;
  assign FULL  = full;
  assign EMPTY = empty;
  assign CNT   = cnt_q;
  assign OVF   = flg_q[FLAG_OVF];
  assign UDF   = flg_q[FLAG_UDF];

`ifndef FUNCTIONAL
  logic unused_notifier;
  specify
    $setup(D, posedge CLK, 0, unused_notifier);
    $hold(posedge CLK, D, 0, unused_notifier);
    $setup(E, posedge CLK, 0, unused_notifier);
    $hold(posedge CLK, E, 0, unused_notifier);
    $setup(RE, posedge CLK, 0, unused_notifier);
    $hold(posedge CLK, RE, 0, unused_notifier);
    $setup(R, posedge CLK, 0, unused_notifier);
    $hold(posedge CLK, R, 0, unused_notifier);
  endspecify
`endif

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__latfifo.sv
// Directed bench: show-ahead and registered-Q instances driven in lockstep.
module tb_gf180mcu_fd_sc_mcu9t5v0__latfifo;

  logic       clk_sys = 1'b0;
  logic       r, e, re, clr;
  logic [3:0] d;
  logic [3:0] q, s0_q;
  logic       full, empty, ovf, udf;
  logic       s0_full, s0_empty, s0_ovf, s0_udf;
  logic [2:0] cnt, s0_cnt;
  int         checks = 0;
  int         errors = 0;

`ifdef USE_POWER_PINS
  wire vdd, vss;
`endif

  always #5 clk_sys = ~clk_sys;

  gf180mcu_fd_sc_mcu9t5v0__latfifo #(.WIDTH(4), .DEPTH(4), .SHOWAHEAD(1)) dut (
`ifdef USE_POWER_PINS
    .VDD(vdd), .VSS(vss),
`endif
    .CLK(clk_sys), .R(r), .D(d), .E(e), .RE(re), .CLR(clr),
    .Q(q), .FULL(full), .EMPTY(empty), .CNT(cnt), .OVF(ovf), .UDF(udf)
  );

  gf180mcu_fd_sc_mcu9t5v0__latfifo #(.WIDTH(4), .DEPTH(4), .SHOWAHEAD(0)) dut_s0 (
`ifdef USE_POWER_PINS
    .VDD(vdd), .VSS(vss),
`endif
    .CLK(clk_sys), .R(r), .D(d), .E(e), .RE(re), .CLR(clr),
    .Q(s0_q), .FULL(s0_full), .EMPTY(s0_empty), .CNT(s0_cnt), .OVF(s0_ovf), .UDF(s0_udf)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic push(input logic [3:0] v);
    d = v; e = 1'b1;
    tick();
    e = 1'b0;
  endtask

  task automatic pop();
    re = 1'b1;
    tick();
    re = 1'b0;
  endtask

  initial begin
    logic [3:0] exp_seq [4];
    r = 1'b1; e = 1'b0; re = 1'b0; clr = 1'b0; d = 4'h0;
    tick(); tick();
    r = 1'b0;
    chk("rst_cnt", cnt, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_q", q, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_udf", udf, 0);
    chk("rst_s0_q", s0_q, 0);

    // fill, then overflow
    for (int i = 1; i <= 4; i++) begin
      push(4'(i));
      chk("fill_cnt", cnt, i);
      chk("fill_q_head", q, 1);
    end
    chk("fill_full", full, 1);
    chk("fill_s0_q", s0_q, 0);
    push(4'h5);
    chk("ovf_set", ovf, 1);
    chk("ovf_cnt", cnt, 4);
    chk("ovf_s0", s0_ovf, 1);

    for (int i = 1; i <= 4; i++) begin
      chk("drain_q", q, i);
      pop();
      chk("drain_s0_q", s0_q, i);
    end
    chk("drain_empty", empty, 1);
    chk("drain_hold_q", q, 4);
    chk("drain_udf", udf, 0);

    // underflow, then push+pop on empty
    pop();
    chk("udf_set", udf, 1);
    chk("udf_cnt", cnt, 0);
    chk("udf_hold_q", q, 4);
    d = 4'h7; e = 1'b1; re = 1'b1;
    tick();
    e = 1'b0; re = 1'b0;
    chk("epp_cnt", cnt, 1);
    chk("epp_q", q, 7);
    chk("epp_s0_q", s0_q, 4);
    pop();
    chk("epp_pop_s0", s0_q, 7);
    chk("epp_empty", empty, 1);

    // push+pop while full
    for (int i = 1; i <= 4; i++) push(4'(i));
    d = 4'hA; e = 1'b1; re = 1'b1;
    tick();
    e = 1'b0; re = 1'b0;
    chk("fpp_cnt", cnt, 4);
    chk("fpp_s0_q", s0_q, 1);
    chk("fpp_full", full, 1);
    exp_seq[0] = 4'h2; exp_seq[1] = 4'h3; exp_seq[2] = 4'h4; exp_seq[3] = 4'hA;
    for (int i = 0; i < 4; i++) begin
      chk("fpp_q", q, exp_seq[i]);
      pop();
    end
    chk("fpp_last_s0", s0_q, 4'hA);
    chk("fpp_empty", empty, 1);

    // wrap-around pairs
    for (int i = 0; i < 10; i++) begin
      push(4'(i));
      chk("wrap_cnt1", cnt, 1);
      chk("wrap_q", q, i);
      pop();
      chk("wrap_cnt0", cnt, 0);
      chk("wrap_s0_q", s0_q, i);
    end

    // flush with a concurrent push
    push(4'hB); push(4'hC); push(4'hD);
    chk("clr_pre_cnt", cnt, 3);
    d = 4'hF; e = 1'b1; clr = 1'b1;
    tick();
    e = 1'b0; clr = 1'b0;
    chk("clr_cnt", cnt, 0);
    chk("clr_empty", empty, 1);
    chk("clr_ovf", ovf, 1);
    chk("clr_udf", udf, 1);
    chk("clr_hold_q", q, 4'hB);
    chk("clr_s0_q", s0_q, 9);
    push(4'h6);
    chk("post_clr_q", q, 6);
    push(4'h8);
    chk("post_clr_cnt", cnt, 2);

    // reset mid-stream wins over CLR/E
    d = 4'h5; e = 1'b1; clr = 1'b1; r = 1'b1;
    tick();
    e = 1'b0; clr = 1'b0; r = 1'b0;
    chk("mrst_cnt", cnt, 0);
    chk("mrst_empty", empty, 1);
    chk("mrst_ovf", ovf, 0);
    chk("mrst_udf", udf, 0);
    chk("mrst_q", q, 0);
    chk("mrst_s0_q", s0_q, 0);
    push(4'h9);
    chk("mrst_push_q", q, 9);
    chk("mrst_push_cnt", cnt, 1);
    pop();
    chk("mrst_pop_s0", s0_q, 9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
